// File: rtl/mips_pkg.sv
// Shared constants for the register-file writeback slice.
// Default address/word widths and the hard-wired zero register index.
package mips_pkg;

  localparam int ADDR_SIZE  = 5;
  localparam int WORD_SIZE  = 32;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ADDR_SIZE-1:0] REG_ZERO = {ADDR_SIZE{1'b0}};

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that queues long-latency results awaiting a free
// register-file write slot. Count-based full/empty, pointers wrap at DEPTH.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign push_s    = push && !full;
  assign pop_s     = pop && !empty;
  assign head_data = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Sole writer of the register-file write port: merges zero-latency pipeline
// writeback with queued long-latency results, tracks pending destinations and
// forwards the write of the current cycle to both read ports.
module reg_writeback #(
  parameter int ADDR_SIZE = mips_pkg::ADDR_SIZE,
  parameter int WORD_SIZE = mips_pkg::WORD_SIZE,
  parameter int DEPTH     = mips_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 iss_valid,
  input  logic [ADDR_SIZE-1:0] iss_addr,
  output logic                 iss_busy,
  input  logic [ADDR_SIZE-1:0] s_addr,
  input  logic [WORD_SIZE-1:0] s_rf_data,
  output logic [WORD_SIZE-1:0] s_fwd_data,
  output logic                 s_busy,
  input  logic [ADDR_SIZE-1:0] t_addr,
  input  logic [WORD_SIZE-1:0] t_rf_data,
  output logic [WORD_SIZE-1:0] t_fwd_data,
  output logic                 t_busy,
  output logic                 d_we,
  output logic [ADDR_SIZE-1:0] d_addr,
  output logic [WORD_SIZE-1:0] d_data
);

  import mips_pkg::REG_ZERO;

  localparam int NREG = 2 ** ADDR_SIZE;
  localparam int FW   = ADDR_SIZE + WORD_SIZE;
  localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(REG_ZERO);

  logic                 primary_s;
  logic                 sec_commit_s;
  logic                 fifo_push_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic [FW-1:0]        head_s;
  logic [ADDR_SIZE-1:0] head_addr_s;
  logic [WORD_SIZE-1:0] head_data_s;
  logic                 iss_set_s;
  logic [NREG-1:0]      pending_r;
  logic [NREG-1:0]      pending_nxt_s;

  function automatic logic [WORD_SIZE-1:0] fwd_sel(
    input logic [ADDR_SIZE-1:0] rd_addr,
    input logic [WORD_SIZE-1:0] rf_data,
    input logic                 we,
    input logic [ADDR_SIZE-1:0] waddr,
    input logic [WORD_SIZE-1:0] wdata
  );
    if (rd_addr == ZERO_ADDR) begin
      return {WORD_SIZE{1'b0}};
    end else if (we && (waddr == rd_addr)) begin
      return wdata;
    end else begin
      return rf_data;
    end
  endfunction

  // Writes to r0 never reach the queue; pipeline writes always win the port.
  assign primary_s    = wb_we && (wb_addr != ZERO_ADDR);
  assign ld_ready     = !fifo_full_s && !rst;
  assign fifo_push_s  = ld_valid && ld_ready && (ld_addr != ZERO_ADDR);
  assign sec_commit_s = !rst && !primary_s && !fifo_empty_s;
  assign iss_set_s    = iss_valid && !rst && (iss_addr != ZERO_ADDR);
  assign head_addr_s  = head_s[FW-1:WORD_SIZE];
  assign head_data_s  = head_s[WORD_SIZE-1:0];

  wb_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data ({ld_addr, ld_data}),
    .pop       (sec_commit_s),
    .head_data (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // Write-port arbitration.
  always_comb begin
    d_we   = 1'b0;
    d_addr = ZERO_ADDR;
    d_data = {WORD_SIZE{1'b0}};
    if (primary_s && !rst) begin
      d_we   = 1'b1;
      d_addr = wb_addr;
      d_data = wb_data;
    end else if (sec_commit_s) begin
      d_we   = 1'b1;
      d_addr = head_addr_s;
      d_data = head_data_s;
    end else begin
      d_we   = 1'b0;
    end
  end

  // Scoreboard next state: a new issue outranks a commit to the same register.
  always_comb begin
    pending_nxt_s = pending_r;
    for (int i = 0; i < NREG; i++) begin
      if (iss_set_s && (iss_addr == ADDR_SIZE'(i))) begin
        pending_nxt_s[i] = 1'b1;
      end else if (sec_commit_s && (head_addr_s == ADDR_SIZE'(i))) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i];
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // A register whose result commits this cycle is already forwardable.
  assign iss_busy = !rst && pending_r[iss_addr];
  assign s_busy   = !rst && pending_r[s_addr] && !(sec_commit_s && (head_addr_s == s_addr));
  assign t_busy   = !rst && pending_r[t_addr] && !(sec_commit_s && (head_addr_s == t_addr));

  assign s_fwd_data = fwd_sel(s_addr, s_rf_data, d_we, d_addr, d_data);
  assign t_fwd_data = fwd_sel(t_addr, t_rf_data, d_we, d_addr, d_data);

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_reg_writeback;

  localparam int AW    = 5;
  localparam int WW    = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [WW-1:0] wb_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [WW-1:0] ld_data;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          iss_busy;
  logic [AW-1:0] s_addr;
  logic [WW-1:0] s_rf_data;
  logic [WW-1:0] s_fwd_data;
  logic          s_busy;
  logic [AW-1:0] t_addr;
  logic [WW-1:0] t_rf_data;
  logic [WW-1:0] t_fwd_data;
  logic          t_busy;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [WW-1:0] d_data;

  reg_writeback #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_busy(iss_busy),
    .s_addr(s_addr), .s_rf_data(s_rf_data), .s_fwd_data(s_fwd_data), .s_busy(s_busy),
    .t_addr(t_addr), .t_rf_data(t_rf_data), .t_fwd_data(t_fwd_data), .t_busy(t_busy),
    .d_we(d_we), .d_addr(d_addr), .d_data(d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending flags per register plus a queue of accepted results.
  bit            pend [32];
  logic [AW-1:0] qa [$];
  logic [WW-1:0] qd [$];
  logic          e_we, e_commit, e_ready;
  logic [AW-1:0] e_addr;
  logic [WW-1:0] e_data;

  int vectors = 0;
  int miscompares = 0;
  int wb_pct = 50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] m_fwd(input logic [AW-1:0] a, input logic [WW-1:0] rf);
    if (a == 5'd0) return 32'd0;
    if (e_we && e_addr == a) return e_data;
    return rf;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (rst) return 1'b0;
    return pend[a] && !(e_commit && qa[0] == a);
  endfunction

  task automatic idle();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
    iss_valid = 1'b0; iss_addr = 5'd0;
    s_addr = 5'd0; s_rf_data = 32'd0; t_addr = 5'd0; t_rf_data = 32'd0;
  endtask

  // Compare every DUT output against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    e_ready  = !rst && (qa.size() < DEPTH);
    e_commit = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (!rst) begin
      if (wb_we && wb_addr != 5'd0) begin
        e_we = 1'b1; e_addr = wb_addr; e_data = wb_data;
      end else if (qa.size() > 0) begin
        e_we = 1'b1; e_commit = 1'b1; e_addr = qa[0]; e_data = qd[0];
      end
    end
    chk("d_we", 32'(d_we), 32'(e_we));
    if (e_we) begin
      chk("d_addr", 32'(d_addr), 32'(e_addr));
      chk("d_data", d_data, e_data);
    end
    chk("ld_ready", 32'(ld_ready), 32'(e_ready));
    chk("iss_busy", 32'(iss_busy), 32'(!rst && pend[iss_addr]));
    chk("s_busy", 32'(s_busy), 32'(m_busy(s_addr)));
    chk("t_busy", 32'(t_busy), 32'(m_busy(t_addr)));
    chk("s_fwd", s_fwd_data, m_fwd(s_addr, s_rf_data));
    chk("t_fwd", t_fwd_data, m_fwd(t_addr, t_rf_data));
  endtask

  // Apply the rules of the clock edge to the model.
  task automatic advance();
    logic [AW-1:0] ca;
    @(posedge clk);
    if (rst) begin
      qa.delete(); qd.delete();
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    end else begin
      if (e_commit) begin
        ca = qa.pop_front();
        void'(qd.pop_front());
        pend[ca] = 1'b0;
      end
      if (iss_valid && iss_addr != 5'd0) pend[iss_addr] = 1'b1;
      if (ld_valid && e_ready && ld_addr != 5'd0) begin
        qa.push_back(ld_addr); qd.push_back(ld_data);
      end
    end
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    sample();
    chk("rst_d_we", 32'(d_we), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    advance();
    sample(); advance();
    rst = 1'b0;
    sample();
    chk("post_rst_ready", 32'(ld_ready), 32'd1);
    advance();

    // Primary write, zero-latency forward.
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    s_addr = 5'd3; s_rf_data = 32'h11111111;
    sample();
    chk("prim_d_we", 32'(d_we), 32'd1);
    chk("prim_d_addr", 32'(d_addr), 32'd3);
    chk("prim_d_data", d_data, 32'hDEADBEEF);
    chk("prim_fwd", s_fwd_data, 32'hDEADBEEF);
    advance();

    // Register zero.
    idle();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000CAFE;
    s_addr = 5'd0; s_rf_data = 32'h5;
    sample();
    chk("zero_d_we", 32'(d_we), 32'd0);
    chk("zero_fwd", s_fwd_data, 32'd0);
    advance();

    // Load path through the queue.
    idle(); iss_valid = 1'b1; iss_addr = 5'd7;
    sample(); advance();
    idle(); s_addr = 5'd7; ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234;
    sample();
    chk("ld_busy_before", 32'(s_busy), 32'd1);
    advance();
    idle(); s_addr = 5'd7;
    sample();
    chk("ld_commit_addr", 32'(d_addr), 32'd7);
    chk("ld_commit_busy", 32'(s_busy), 32'd0);
    chk("ld_commit_fwd", s_fwd_data, 32'h1234);
    advance();
    sample();
    chk("ld_after_busy", 32'(s_busy), 32'd0);
    advance();

    // Contention: continuous primary traffic starves the queue.
    idle(); wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h100;
    ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'hA;
    sample(); advance();
    ld_addr = 5'd5; ld_data = 32'hB; wb_data = 32'h101;
    sample(); advance();
    ld_addr = 5'd6; ld_data = 32'hC;
    for (int k = 0; k < 3; k++) begin
      wb_data = 32'(k);
      sample();
      chk("cont_ready", 32'(ld_ready), 32'd0);
      chk("cont_d_addr", 32'(d_addr), 32'd10);
      advance();
    end
    idle();
    sample();
    chk("drain4_addr", 32'(d_addr), 32'd4);
    chk("drain4_data", d_data, 32'hA);
    advance();
    sample();
    chk("drain5_addr", 32'(d_addr), 32'd5);
    chk("drain5_ready", 32'(ld_ready), 32'd1);
    advance();
    sample();
    chk("drain_idle", 32'(d_we), 32'd0);
    advance();

    // Set/clear race on register 9.
    idle(); iss_valid = 1'b1; iss_addr = 5'd9;
    sample(); advance();
    idle(); ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
    sample(); advance();
    idle(); iss_valid = 1'b1; iss_addr = 5'd9;
    sample();
    chk("race_commit", 32'(d_addr), 32'd9);
    advance();
    idle(); s_addr = 5'd9;
    sample();
    chk("race_pending", 32'(s_busy), 32'd1);
    advance();

    // Reset with a full queue and a pending register.
    idle(); iss_valid = 1'b1; iss_addr = 5'd4;
    sample(); advance();
    idle(); wb_we = 1'b1; wb_addr = 5'd12; ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h44;
    sample(); advance();
    ld_addr = 5'd6; ld_data = 32'h66;
    sample(); advance();
    idle(); rst = 1'b1; s_addr = 5'd4;
    sample();
    chk("mid_rst_d_we", 32'(d_we), 32'd0);
    chk("mid_rst_busy", 32'(s_busy), 32'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("after_rst_d_we", 32'(d_we), 32'd0);
    chk("after_rst_ready", 32'(ld_ready), 32'd1);
    chk("after_rst_busy", 32'(s_busy), 32'd0);
    advance();

    // Randomized traffic honouring the issue/writeback protocol.
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) wb_pct = int'($urandom_range(10, 95));
      rst = ($urandom_range(0, 299) == 0);
      wb_addr = pick_addr();
      wb_data = $urandom;
      wb_we = ($urandom_range(0, 99) < wb_pct) && !pend[wb_addr];
      iss_addr = pick_addr();
      iss_valid = ($urandom_range(0, 3) == 0) && !pend[iss_addr];
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr = pick_addr();
      ld_data = $urandom;
      s_addr = pick_addr(); s_rf_data = $urandom;
      t_addr = pick_addr(); t_rf_data = $urandom;
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
